attention_score_unit: RTL and testbench
=======================================

# attention_score_unit

Downstream stage of the QKV projection engine. Once Q, K and V are in result SRAM, this block computes the raw attention score matrix S = Q·Kᵀ (L×L, unscaled, integer) and writes it row-major to scratchpad SRAM. It buffers one Q row locally so that result SRAM needs only a single read port.

## Interface

**Parameters**
- DATA_W, 32: SRAM word width.
- ADDR_W, 16: SRAM address width.
- MAX_DIM, 64: depth of the Q-row buffer, i.e. the maximum supported D.

**Ports**
- clk, input, 1: the single clock.
- reset, input, 1: synchronous, active-high reset.
- start_valid, input, 1: job request.
- start_ready, output, 1: high when idle.
- seq_len, input, 16: L, the number of tokens. Sampled at start acceptance.
- dim, input, 16: D, the row length of Q and K. Sampled at start acceptance.
- done, output, 1: one-cycle pulse at job end.
- err, output, 1: valid with done. High if D > MAX_DIM.
- result_read_address, output, ADDR_W: result SRAM read address.
- result_read_data, input, DATA_W: result SRAM data, valid 1 cycle after its address.
- scratchpad_write_enable, output, 1: scratchpad write strobe.
- scratchpad_write_address, output, ADDR_W: scratchpad write address.
- scratchpad_write_data, output, DATA_W: scratchpad write data.

## Operation

- **Memory layout (fixed)**
  - Q[i][j] is at address i·D+j.
  - K[k][j] is at address L·D + k·D + j.
  - S[i][k] is written to scratchpad address i·L+k.
- **Arithmetic**
  - Each product is 32×32 truncated to the low 32 bits.
  - The accumulator is 32 bits and wraps modulo 2³².
  - The accumulator reloads, rather than adds, on the first element of each K row.
- **FSM states and transitions**
  - IDLE: start_ready=1. On start_valid, latch L and D and go to SETUP.
  - SETUP (1 cycle): compute k_base = L·D and clear the counters i, k, j.
    - If L=0 or D=0, go to FIN with err=0.
    - If D > MAX_DIM, go to FIN with err=1.
    - Otherwise go to LOADQ.
  - LOADQ: issue reads Q[i][0..D-1], one per cycle. Each data word is written into buffer[j] one cycle later. After the last issue, go to MACK.
  - MACK: issue K[k][0..D-1] back-to-back for k = 0..L-1.
    - Each returning word is multiplied by buffer[j] and accumulated.
    - The finished sum is registered into the scratchpad write one cycle after its last data word.
    - After the last issue: if i < L-1, increment i and go to LOADQ; otherwise go to DRAIN.
  - DRAIN (2 cycles): absorb the final data word and the final write, then go to FIN.
  - FIN: pulse done for 1 cycle, then go to IDLE.
- **Boundary rules**
  - start_valid while busy is ignored and never queued.
  - A LOADQ issue and the buffer write of the previous row's Q data cannot collide. The buffer write always precedes the MAC use by at least one cycle.
  - L·D and L·L are taken modulo 2^ADDR_W. Software guarantees these fit.
  - reset in any state: go to IDLE the next cycle. All outputs return to reset values. Scratchpad contents written so far are left as they are.

## Timing

- **Reset values**
  - start_ready = 1.
  - done = 0, err = 0.
  - scratchpad_write_enable = 0.
  - All address and data outputs = 0.
- **Cycle numbering:** start accepted in cycle 0; SETUP in cycle 1. Let N = L·D·(L+1).
- **Reads**
  - Issued in cycles 2..N+1 with no bubbles.
  - result_read_address is registered.
- **Writes**
  - The write for S[i][k] is asserted 2 cycles after the issue of K[k][D-1].
  - The last write is in cycle N+3.
- **Completion**
  - done is in cycle N+4.
  - start_ready rises in cycle N+5.
- **Degenerate jobs** (L=0, D=0, or err): done in cycle 2, with no reads and no writes.

## Structure

- **Package attn_pkg**
  - FSM state enum: IDLE, SETUP, LOADQ, MACK, DRAIN, FIN.
  - DATA_W and ADDR_W defaults.
  - Function `idx_w(MAX_DIM)` for the buffer index width.
- **Sub-module qrow_buffer**
  - MAX_DIM × DATA_W register file.
  - One synchronous write port, one combinational read port.
  - No reset on the storage.

## Test plan

- **Basic 2×2:** L=2, D=2, Q=[[1,2],[3,4]], K=[[5,6],[7,8]] → scratchpad 0..3 = 17, 23, 39, 53. done in cycle 16. Exactly 4 write strobes.
- **Wrap-around:** L=1, D=1, Q=0xFFFFFFFF, K=2 → scratchpad[0] = 0xFFFFFFFE. Also L=1, D=2, Q=[0x80000000, 0x80000000], K=[2,2] → 0x00000000.
- **Degenerate and error:**
  - D=0 → done in cycle 2, no write strobes, err=0.
  - D=MAX_DIM+1 → done in cycle 2, err=1.
- **Busy start:** start_valid held high throughout an L=3, D=4 job → exactly one job runs. start_ready=0 from cycle 1 through cycle N+4. A second job is accepted only at or after cycle N+5.
- **Reset mid-job:** assert reset during MACK of an L=4, D=4 job → the next cycle has start_ready=1, write_enable=0 and done=0. A fresh 2×2 job then produces the correct results.
- **Random:** L, D ∈ [1, 8] with random 32-bit data, compared against a reference model. Check both the write ordering (addresses 0..L²-1 ascending) and the exact done cycle.

Source files
------------

// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention score unit.
package attn_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOADQ,
        MACK,
        DRAIN,
        FIN
    } state_e;

    // Width of an index into the Q-row buffer.
    function automatic int idx_w(input int max_dim);
        return (max_dim > 1) ? $clog2(max_dim) : 1;
    endfunction

endpackage

// File: rtl/qrow_buffer.sv
// One Q row held locally: synchronous write, combinational read, no reset on storage.
module qrow_buffer
    import attn_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_DIM = 64,
    parameter int IDX_W   = idx_w(MAX_DIM)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [MAX_DIM];

    // Capture a returning Q word into its column slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/attention_score_unit.sv
// Computes S = Q*K^T from result SRAM into scratchpad SRAM, one Q row buffered at a time.
module attention_score_unit
    import attn_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MAX_DIM = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [15:0]       seq_len,
    input  logic [15:0]       dim,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] result_read_address,
    input  logic [DATA_W-1:0] result_read_data,
    output logic              scratchpad_write_enable,
    output logic [ADDR_W-1:0] scratchpad_write_address,
    output logic [DATA_W-1:0] scratchpad_write_data
);

    localparam int IDX_W = idx_w(MAX_DIM);

    // Products and sums wrap modulo 2^DATA_W; the first term of a K row reloads.
    function automatic logic [DATA_W-1:0] mac_wrap(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic              reload);
        logic [DATA_W-1:0] prod;
        prod = a * b;
        return reload ? prod : acc + prod;
    endfunction

    state_e state_q, state_d;
    logic [15:0] len_q, len_d, dim_q, dim_d;
    logic [15:0] i_q, i_d, k_q, k_d, j_q, j_d;
    logic [ADDR_W-1:0] kbase_q, kbase_d, qbase_q, qbase_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wcnt_q, wcnt_d;
    logic err_q, err_d, drain_q, drain_d;

    logic vld_p1_q, vld_p1_d, isk_p1_q, isk_p1_d;
    logic first_p1_q, first_p1_d, last_p1_q, last_p1_d;
    logic [IDX_W-1:0] j_p1_q, j_p1_d;

    logic [DATA_W-1:0] acc_q, acc_d, mac_sum, buf_rd;
    logic swe_q, swe_d;
    logic [ADDR_W-1:0] swa_q, swa_d;
    logic [DATA_W-1:0] swd_q, swd_d;

    qrow_buffer #(
        .DATA_W (DATA_W),
        .MAX_DIM(MAX_DIM),
        .IDX_W  (IDX_W)
    ) u_qbuf (
        .clk    (clk),
        .wr_en  (vld_p1_q & ~isk_p1_q),
        .wr_idx (j_p1_q),
        .wr_data(result_read_data),
        .rd_idx (j_p1_q),
        .rd_data(buf_rd)
    );

    assign mac_sum = mac_wrap(acc_q, result_read_data, buf_rd, first_p1_q);

    // Next-state, read issue sequencing and write-back pipeline.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        dim_d      = dim_q;
        err_d      = err_q;
        kbase_d    = kbase_q;
        qbase_d    = qbase_q;
        i_d        = i_q;
        k_d        = k_q;
        j_d        = j_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        drain_d    = drain_q;
        vld_p1_d   = 1'b0;
        isk_p1_d   = 1'b0;
        first_p1_d = 1'b0;
        last_p1_d  = 1'b0;
        j_p1_d     = IDX_W'(j_q);

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    len_d   = seq_len;
                    dim_d   = dim;
                    err_d   = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                kbase_d = ADDR_W'(len_q) * ADDR_W'(dim_q);
                qbase_d = '0;
                i_d     = '0;
                k_d     = '0;
                j_d     = '0;
                addr_d  = '0;
                wcnt_d  = '0;
                if (len_q == 16'd0 || dim_q == 16'd0) begin
                    state_d = FIN;
                end else if (dim_q > 16'(MAX_DIM)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = LOADQ;
                end
            end
            LOADQ: begin
                vld_p1_d = 1'b1;
                if (j_q == dim_q - 16'd1) begin
                    j_d     = '0;
                    k_d     = '0;
                    addr_d  = kbase_q;
                    state_d = MACK;
                end else begin
                    j_d    = j_q + 16'd1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            MACK: begin
                vld_p1_d   = 1'b1;
                isk_p1_d   = 1'b1;
                first_p1_d = (j_q == 16'd0);
                last_p1_d  = (j_q == dim_q - 16'd1);
                if (j_q == dim_q - 16'd1) begin
                    j_d = '0;
                    if (k_q == len_q - 16'd1) begin
                        if (i_q == len_q - 16'd1) begin
                            drain_d = 1'b0;
                            state_d = DRAIN;
                        end else begin
                            i_d     = i_q + 16'd1;
                            k_d     = '0;
                            qbase_d = qbase_q + ADDR_W'(dim_q);
                            addr_d  = qbase_q + ADDR_W'(dim_q);
                            state_d = LOADQ;
                        end
                    end else begin
                        k_d    = k_q + 16'd1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else begin
                    j_d    = j_q + 16'd1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // stage p1 -> write-back: data word arrives, MAC and register the finished sum
        acc_d = acc_q;
        swe_d = 1'b0;
        swa_d = swa_q;
        swd_d = swd_q;
        if (vld_p1_q && isk_p1_q) begin
            acc_d = mac_sum;
            if (last_p1_q) begin
                swe_d  = 1'b1;
                swa_d  = wcnt_q;
                swd_d  = mac_sum;
                wcnt_d = wcnt_q + ADDR_W'(1);
            end
        end
    end

    // Control and output registers, returned to idle values by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            err_q    <= 1'b0;
            vld_p1_q <= 1'b0;
            swe_q    <= 1'b0;
            swa_q    <= '0;
            swd_q    <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            vld_p1_q <= vld_p1_d;
            swe_q    <= swe_d;
            swa_q    <= swa_d;
            swd_q    <= swd_d;
            addr_q   <= addr_d;
        end
    end

    // Job parameters, counters and datapath registers; initialised in SETUP before use.
    always_ff @(posedge clk) begin
        len_q      <= len_d;
        dim_q      <= dim_d;
        kbase_q    <= kbase_d;
        qbase_q    <= qbase_d;
        i_q        <= i_d;
        k_q        <= k_d;
        j_q        <= j_d;
        wcnt_q     <= wcnt_d;
        drain_q    <= drain_d;
        isk_p1_q   <= isk_p1_d;
        first_p1_q <= first_p1_d;
        last_p1_q  <= last_p1_d;
        j_p1_q     <= j_p1_d;
        acc_q      <= acc_d;
    end

    assign start_ready              = (state_q == IDLE);
    assign done                     = (state_q == FIN);
    assign err                      = (state_q == FIN) & err_q;
    assign result_read_address      = addr_q;
    assign scratchpad_write_enable  = swe_q;
    assign scratchpad_write_address = swa_q;
    assign scratchpad_write_data    = swd_q;

endmodule

// File: tb/tb_attention_score_unit.sv
// Self-checking bench for attention_score_unit: vector table, corner sequences, random jobs.
module tb_attention_score_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] seq_len;
    logic [15:0] dim;
    logic        done;
    logic        err;
    logic [15:0] raddr;
    logic [31:0] rdata;
    logic        swe;
    logic [15:0] swa;
    logic [31:0] swd;

    always #5 clk = ~clk;

    attention_score_unit #(
        .DATA_W (32),
        .ADDR_W (16),
        .MAX_DIM(64)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start_valid             (start_valid),
        .start_ready             (start_ready),
        .seq_len                 (seq_len),
        .dim                     (dim),
        .done                    (done),
        .err                     (err),
        .result_read_address     (raddr),
        .result_read_data        (rdata),
        .scratchpad_write_enable (swe),
        .scratchpad_write_address(swa),
        .scratchpad_write_data   (swd)
    );

    // Result SRAM model: one-cycle read latency.
    logic [31:0] rmem [0:255];
    always @(posedge clk) rdata <= rmem[raddr[7:0]];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic [31:0] exp_s[$];
    int          done_cyc;
    logic        err_at_done;
    int          ready_early;
    int          extra_act;

    typedef struct {
        int               L;
        int               D;
        logic [7:0][31:0] mem;
        int               nw;
        logic [3:0][31:0] s;
        int               done_c;
        bit               err;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain dot-product model of S = Q*K^T with 32-bit wrap.
    task automatic model(input int L, input int D);
        logic [31:0] acc;
        exp_s.delete();
        for (int i = 0; i < L; i++) begin
            for (int k = 0; k < L; k++) begin
                acc = '0;
                for (int j = 0; j < D; j++) acc = acc + rmem[i*D+j] * rmem[L*D + k*D + j];
                exp_s.push_back(acc);
            end
        end
    endtask

    // Start a job at a negedge (cycle 0) and record writes/done with cycle numbers.
    task automatic run_job(input int L, input int D, input bit hold);
        int c;
        int w;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        done_cyc = -1; err_at_done = 1'b0; ready_early = 0; extra_act = 0;
        @(negedge clk);
        seq_len = 16'(L); dim = 16'(D); start_valid = 1'b1;
        w = 0;
        while (!start_ready && w < 50) begin @(negedge clk); w++; end
        chk("start_ready_at_accept", start_ready, 1);
        c = 0;
        while (done_cyc < 0 && c < 3000) begin
            @(negedge clk); c++;
            if (!hold) start_valid = 1'b0;
            if (start_ready) ready_early++;
            if (swe) begin wa_q.push_back(int'(swa)); wd_q.push_back(swd); wc_q.push_back(c); end
            if (done) begin done_cyc = c; err_at_done = err; end
        end
        chk("done_seen", (done_cyc >= 0), 1);
        @(negedge clk);
        chk("start_ready_after_done", start_ready, 1);
        start_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (swe || done || !start_ready) extra_act++;
        end
    endtask

    task automatic verify(input string nm, input int L, input int D,
                          input int exp_done, input bit exp_err, input int nw);
        chk({nm, "_done_cycle"}, done_cyc, exp_done);
        chk({nm, "_err"}, err_at_done, exp_err);
        chk({nm, "_write_count"}, wa_q.size(), nw);
        chk({nm, "_busy_ready"}, ready_early, 0);
        chk({nm, "_post_idle"}, extra_act, 0);
        for (int n = 0; n < wa_q.size() && n < nw; n++) begin
            chk($sformatf("%s_addr%0d", nm, n), wa_q[n], n);
            chk($sformatf("%s_data%0d", nm, n), wd_q[n], exp_s[n]);
            chk($sformatf("%s_wcyc%0d", nm, n), wc_q[n], (n/L)*D*(L+1) + (n%L + 2)*D + 3);
        end
    endtask

    task automatic apply_vec(input int t);
        for (int a = 0; a < 8; a++) rmem[a] = tbl[t].mem[a];
        exp_s.delete();
        for (int n = 0; n < tbl[t].nw; n++) exp_s.push_back(tbl[t].s[n]);
        run_job(tbl[t].L, tbl[t].D, 1'b0);
        verify($sformatf("vec%0d", t), tbl[t].L, tbl[t].D, tbl[t].done_c, tbl[t].err, tbl[t].nw);
    endtask

    task automatic fill_random(input int L, input int D);
        for (int a = 0; a < 256; a++) rmem[a] = '0;
        for (int a = 0; a < 2*L*D; a++) rmem[a] = $urandom;
    endtask

    initial begin
        tbl[0] = '{2, 2, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 4,
                   {32'd53, 32'd39, 32'd23, 32'd17}, 16, 1'b0};
        tbl[1] = '{1, 1, {192'd0, 32'd2, 32'hFFFF_FFFF}, 1, {96'd0, 32'hFFFF_FFFE}, 6, 1'b0};
        tbl[2] = '{1, 2, {128'd0, 32'd2, 32'd2, 32'h8000_0000, 32'h8000_0000}, 1,
                   {96'd0, 32'h0000_0000}, 8, 1'b0};
        tbl[3] = '{2, 0, '0, 0, '0, 2, 1'b0};
        tbl[4] = '{0, 3, '0, 0, '0, 2, 1'b0};
        tbl[5] = '{1, 65, '0, 0, '0, 2, 1'b1};
        for (int a = 0; a < 256; a++) rmem[a] = '0;

        reset = 1'b1; start_valid = 1'b0; seq_len = '0; dim = '0;
        repeat (3) @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_write_enable", swe, 0);
        chk("rst_read_addr", raddr, 0);
        chk("rst_write_addr", swa, 0);
        chk("rst_write_data", swd, 0);
        reset = 1'b0;

        for (int t = 0; t < 6; t++) apply_vec(t);

        // start_valid held high for a whole L=3, D=4 job
        fill_random(3, 4);
        model(3, 4);
        run_job(3, 4, 1'b1);
        verify("busy", 3, 4, 3*4*4 + 4, 1'b0, 9);

        // reset during MACK of an L=4, D=4 job (cycle 10), just before the first write
        fill_random(4, 4);
        @(negedge clk);
        seq_len = 16'd4; dim = 16'd4; start_valid = 1'b1;
        chk("midrst_accept_ready", start_ready, 1);
        repeat (10) begin @(negedge clk); start_valid = 1'b0; end
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_start_ready", start_ready, 1);
        chk("midrst_write_enable", swe, 0);
        chk("midrst_done", done, 0);
        chk("midrst_write_addr", swa, 0);
        reset = 1'b0;
        apply_vec(0);

        // random jobs against the dot-product model
        for (int r = 0; r < 12; r++) begin
            int L;
            int D;
            L = $urandom_range(1, 8);
            D = $urandom_range(1, 8);
            fill_random(L, D);
            model(L, D);
            run_job(L, D, 1'b0);
            verify($sformatf("rnd%0d_L%0d_D%0d", r, L, D), L, D, L*D*(L+1) + 4, 1'b0, L*L);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
